// File: rtl/decode_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : decode_hazard_ctrl
// Purpose  : Pipeline sequencing controller beside the decode-stage forwarding
//            unit. It detects load-use and decode-branch hazards and stalls or
//            flushes the front end so that decode forwarding only sees ready
//            EX/MEM results. It also runs the debug run/halt/single-step
//            sequencing, drains the pipeline after a HALT instruction and
//            keeps a saturating stall-cycle counter for the debug unit.
// Ports    :
//   clock, reset        rising-edge clock, synchronous active-low reset
//   rs_dec, rt_dec      source registers of the instruction in decode
//   dec_uses_rt         decode instruction reads rt
//   dec_is_branch       decode instruction resolves in decode
//   dec_halt            HALT opcode in decode
//   branch_taken        decode compare result (valid with dec_is_branch)
//   id_ex_*             EX-stage write/load flags and destination
//   ex_mem_*            MEM-stage load flag and destination
//   halt_req/run_req/step_req  debug-unit command pulses
//   pc_write, if_id_write      front-end enables
//   if_id_flush, id_ex_bubble  IF/ID zeroing, NOP injection into ID/EX
//   pipe_enable                enable for ID/EX, EX/MEM, MEM/WB
//   halted, program_done       status
//   stall_count                saturating count of stall cycles
// Revision : 1.0 - initial release
// ============================================================================
module decode_hazard_ctrl #(
  parameter int NB_REG       = 5,
  parameter int NB_COUNT     = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NB_REG-1:0]   rs_dec,
  input  logic [NB_REG-1:0]   rt_dec,
  input  logic                dec_uses_rt,
  input  logic                dec_is_branch,
  input  logic                dec_halt,
  input  logic                branch_taken,
  input  logic                id_ex_reg_write,
  input  logic                id_ex_mem_read,
  input  logic [NB_REG-1:0]   id_ex_write_reg,
  input  logic                ex_mem_mem_read,
  input  logic [NB_REG-1:0]   ex_mem_write_reg,
  input  logic                halt_req,
  input  logic                run_req,
  input  logic                step_req,
  output logic                pc_write,
  output logic                if_id_write,
  output logic                if_id_flush,
  output logic                id_ex_bubble,
  output logic                pipe_enable,
  output logic                halted,
  output logic                program_done,
  output logic [NB_COUNT-1:0] stall_count
);

  localparam int NB_DRAIN = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES);
  localparam logic [NB_COUNT-1:0] COUNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_HALTED = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [NB_DRAIN-1:0]   drain_q, drain_d;
  logic [NB_COUNT-1:0]   count_q, count_d;

  // Register zero is never a real producer, so it never creates a hazard.
  function automatic logic reg_match(input logic [NB_REG-1:0] dst,
                                     input logic [NB_REG-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

  logic rt_live;
  logic match_ex;
  logic match_mem;
  logic load_use;
  logic branch_alu;
  logic branch_mem;
  logic active;
  logic hazard;

  // Branches compare both operands in decode, so rt always matters for them.
  assign rt_live    = dec_uses_rt | dec_is_branch;
  assign match_ex   = reg_match(id_ex_write_reg, rs_dec) |
                      (rt_live & reg_match(id_ex_write_reg, rt_dec));
  assign match_mem  = reg_match(ex_mem_write_reg, rs_dec) |
                      (rt_live & reg_match(ex_mem_write_reg, rt_dec));
  assign load_use   = id_ex_mem_read & match_ex;
  assign branch_alu = dec_is_branch & id_ex_reg_write & match_ex;
  assign branch_mem = dec_is_branch & ex_mem_mem_read & match_mem;
  assign active     = (state_q == S_RUN) || (state_q == S_STEP);
  // A branch on a load in EX first trips load_use, then branch_mem once the
  // load reaches MEM, giving the two-cycle stall without extra state.
  assign hazard     = active & (load_use | branch_alu | branch_mem);

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    count_d      = count_q;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_enable  = 1'b0;
    halted       = 1'b0;
    program_done = 1'b0;

    case (state_q)
      S_RUN, S_STEP: begin
        pipe_enable = 1'b1;
        if (hazard) begin
          id_ex_bubble = 1'b1;
          if (count_q != COUNT_MAX) begin
            count_d = count_q + NB_COUNT'(1);
          end
        end else if (dec_halt) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          if_id_flush = dec_is_branch & branch_taken;
        end

        // A taken HALT beats a debug halt request and the end of a step.
        if (!hazard && dec_halt) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (state_q == S_STEP || halt_req) begin
          state_d = S_HALTED;
        end
      end

      S_HALTED: begin
        halted = 1'b1;
        if (run_req) begin
          state_d = S_RUN;
        end else if (step_req) begin
          state_d = S_STEP;
        end
      end

      S_DRAIN: begin
        id_ex_bubble = 1'b1;
        pipe_enable  = 1'b1;
        if (drain_q <= NB_DRAIN'(1)) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q - NB_DRAIN'(1);
        end
      end

      S_DONE: begin
        program_done = 1'b1;
      end

      default: begin
        state_d = S_RUN;
      end
    endcase

    // Reset silences every output in the cycle it is asserted.
    if (!reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_enable  = 1'b0;
      halted       = 1'b0;
      program_done = 1'b0;
    end
  end

  assign stall_count = reset ? count_q : '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_RUN;
      drain_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_hazard_ctrl
// Purpose  : Self-checking bench for decode_hazard_ctrl: directed scenarios
//            plus randomized traffic against a behavioural reference model.
//            A second instance with a 4-bit counter exercises saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_hazard_ctrl;

  localparam int NB_REG   = 5;
  localparam int NB_COUNT = 16;
  localparam int NB_SAT   = 4;
  localparam int DRAIN    = 3;

  // Model mode encoding (bench-local)
  localparam int M_RUN = 0, M_HALTED = 1, M_STEP = 2, M_DRAIN = 3, M_DONE = 4;

  logic              clock;
  logic              reset;
  logic [NB_REG-1:0] rs_dec, rt_dec, id_ex_write_reg, ex_mem_write_reg;
  logic dec_uses_rt, dec_is_branch, dec_halt, branch_taken;
  logic id_ex_reg_write, id_ex_mem_read, ex_mem_mem_read;
  logic halt_req, run_req, step_req;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_enable;
  logic halted, program_done;
  logic [NB_COUNT-1:0] stall_count;
  logic s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_pipe_enable;
  logic s_halted, s_program_done;
  logic [NB_SAT-1:0] s_stall_count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_mode = M_RUN;
  int m_drain = 0;
  int m_cnt = 0;
  int m_cnt_sat = 0;

  decode_hazard_ctrl #(.NB_REG(NB_REG), .NB_COUNT(NB_COUNT), .DRAIN_CYCLES(DRAIN)) dut (
    .clock(clock), .reset(reset), .rs_dec(rs_dec), .rt_dec(rt_dec),
    .dec_uses_rt(dec_uses_rt), .dec_is_branch(dec_is_branch), .dec_halt(dec_halt),
    .branch_taken(branch_taken), .id_ex_reg_write(id_ex_reg_write),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_write_reg(id_ex_write_reg),
    .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_write_reg(ex_mem_write_reg),
    .halt_req(halt_req), .run_req(run_req), .step_req(step_req),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_enable(pipe_enable), .halted(halted),
    .program_done(program_done), .stall_count(stall_count)
  );

  decode_hazard_ctrl #(.NB_REG(NB_REG), .NB_COUNT(NB_SAT), .DRAIN_CYCLES(DRAIN)) dut_sat (
    .clock(clock), .reset(reset), .rs_dec(rs_dec), .rt_dec(rt_dec),
    .dec_uses_rt(dec_uses_rt), .dec_is_branch(dec_is_branch), .dec_halt(dec_halt),
    .branch_taken(branch_taken), .id_ex_reg_write(id_ex_reg_write),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_write_reg(id_ex_write_reg),
    .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_write_reg(ex_mem_write_reg),
    .halt_req(halt_req), .run_req(run_req), .step_req(step_req),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
    .id_ex_bubble(s_id_ex_bubble), .pipe_enable(s_pipe_enable), .halted(s_halted),
    .program_done(s_program_done), .stall_count(s_stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic bit depends(input logic [NB_REG-1:0] d);
    bit rt_live;
    rt_live = dec_uses_rt || dec_is_branch;
    return (d != 0) && ((d == rs_dec) || (rt_live && d == rt_dec));
  endfunction

  function automatic bit model_hazard();
    if (m_mode != M_RUN && m_mode != M_STEP) return 1'b0;
    return (id_ex_mem_read && depends(id_ex_write_reg)) ||
           (dec_is_branch && id_ex_reg_write && depends(id_ex_write_reg)) ||
           (dec_is_branch && ex_mem_mem_read && depends(ex_mem_write_reg));
  endfunction

  // Expected {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_enable, halted, program_done}
  function automatic logic [6:0] model_outputs();
    if (!reset) return 7'b0;
    case (m_mode)
      M_RUN, M_STEP: begin
        if (model_hazard()) return 7'b0001100;
        if (dec_halt)       return {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00};
        return {1'b1, 1'b1, (dec_is_branch && branch_taken), 1'b0, 1'b1, 2'b00};
      end
      M_HALTED: return 7'b0000010;
      M_DRAIN:  return 7'b0001100;
      default:  return 7'b0000001;
    endcase
  endfunction

  task automatic model_step();
    bit hz;
    hz = model_hazard();
    if (!reset) begin
      m_mode = M_RUN; m_drain = 0; m_cnt = 0; m_cnt_sat = 0;
    end else begin
      case (m_mode)
        M_RUN, M_STEP: begin
          if (hz) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_sat < 15) m_cnt_sat++;
          end
          if (!hz && dec_halt) begin
            m_mode = M_DRAIN; m_drain = DRAIN;
          end else if (m_mode == M_STEP || halt_req) begin
            m_mode = M_HALTED;
          end
        end
        M_HALTED: begin
          if (run_req) m_mode = M_RUN;
          else if (step_req) m_mode = M_STEP;
        end
        M_DRAIN: begin
          if (m_drain <= 1) m_mode = M_DONE;
          else m_drain--;
        end
        default: ;
      endcase
    end
  endtask

  // Advance one clock; the model consumes the inputs held during the cycle.
  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    rs_dec = '0; rt_dec = '0; dec_uses_rt = 0; dec_is_branch = 0; dec_halt = 0;
    branch_taken = 0; id_ex_reg_write = 0; id_ex_mem_read = 0; id_ex_write_reg = '0;
    ex_mem_mem_read = 0; ex_mem_write_reg = '0; halt_req = 0; run_req = 0; step_req = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // ---------------- directed tests ----------------
  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    id_ex_mem_read = 1; id_ex_write_reg = 5'd3; rs_dec = 5'd3; // hazard ignored under reset
    tick();
    @(negedge clock);
    total++;
    if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_enable, halted, program_done} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0000000",
               {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_enable, halted, program_done});
    end
    total++;
    if (stall_count !== 16'd0) begin
      bad++; $display("FAIL reset_count got=%0d want=0", stall_count);
    end
    tick();
    clear_inputs();
    reset = 1'b1;
    @(negedge clock);
    total++;
    if (pc_write !== 1'b1 || pipe_enable !== 1'b1 || halted !== 1'b0) begin
      bad++; $display("FAIL reset_run_state pc_write=%b pipe_enable=%b halted=%b want 1 1 0",
                      pc_write, pipe_enable, halted);
    end
    tick();
  endtask

  task automatic test_load_use();
    apply_reset();
    id_ex_mem_read = 1; id_ex_reg_write = 1; id_ex_write_reg = 5'd3; rs_dec = 5'd3;
    @(negedge clock);
    total++;
    if (pc_write !== 0 || if_id_write !== 0 || id_ex_bubble !== 1 || pipe_enable !== 1 || stall_count !== 16'd0) begin
      bad++; $display("FAIL load_use_stall pc=%b ifid=%b bub=%b pe=%b cnt=%0d want 0 0 1 1 0",
                      pc_write, if_id_write, id_ex_bubble, pipe_enable, stall_count);
    end
    tick();
    id_ex_mem_read = 0; id_ex_reg_write = 0; id_ex_write_reg = '0;
    ex_mem_mem_read = 1; ex_mem_write_reg = 5'd3;
    @(negedge clock);
    total++;
    if (pc_write !== 1 || id_ex_bubble !== 0 || stall_count !== 16'd1) begin
      bad++; $display("FAIL load_use_advance pc=%b bub=%b cnt=%0d want 1 0 1",
                      pc_write, id_ex_bubble, stall_count);
    end
    tick();
  endtask

  task automatic test_branch_on_load();
    apply_reset();
    dec_is_branch = 1; branch_taken = 1; rs_dec = 5'd5; rt_dec = 5'd9;
    id_ex_mem_read = 1; id_ex_reg_write = 1; id_ex_write_reg = 5'd5;
    @(negedge clock);
    total++;
    if (pc_write !== 0 || id_ex_bubble !== 1 || if_id_flush !== 0) begin
      bad++; $display("FAIL branch_load_stall1 pc=%b bub=%b flush=%b want 0 1 0",
                      pc_write, id_ex_bubble, if_id_flush);
    end
    tick();
    // load now in MEM, bubble in EX
    id_ex_mem_read = 0; id_ex_reg_write = 0; id_ex_write_reg = '0;
    ex_mem_mem_read = 1; ex_mem_write_reg = 5'd5;
    @(negedge clock);
    total++;
    if (pc_write !== 0 || id_ex_bubble !== 1 || stall_count !== 16'd1) begin
      bad++; $display("FAIL branch_load_stall2 pc=%b bub=%b cnt=%0d want 0 1 1",
                      pc_write, id_ex_bubble, stall_count);
    end
    tick();
    ex_mem_mem_read = 0; ex_mem_write_reg = '0;
    @(negedge clock);
    total++;
    if (pc_write !== 1 || if_id_flush !== 1 || stall_count !== 16'd2) begin
      bad++; $display("FAIL branch_load_resolve pc=%b flush=%b cnt=%0d want 1 1 2",
                      pc_write, if_id_flush, stall_count);
    end
    tick();
    dec_is_branch = 0; branch_taken = 0;
    @(negedge clock);
    total++;
    if (if_id_flush !== 0) begin
      bad++; $display("FAIL branch_flush_once flush=%b want 0", if_id_flush);
    end
    tick();
  endtask

  task automatic test_reg_zero();
    apply_reset();
    id_ex_mem_read = 1; id_ex_write_reg = '0; rs_dec = '0; dec_uses_rt = 1; rt_dec = '0;
    @(negedge clock);
    total++;
    if (pc_write !== 1 || id_ex_bubble !== 0 || stall_count !== 16'd0) begin
      bad++; $display("FAIL reg_zero pc=%b bub=%b cnt=%0d want 1 0 0", pc_write, id_ex_bubble, stall_count);
    end
    tick();
  endtask

  task automatic test_halt_drain();
    apply_reset();
    dec_halt = 1;
    @(negedge clock);
    total++;
    if (if_id_flush !== 1 || pc_write !== 0 || id_ex_bubble !== 1 || pipe_enable !== 1) begin
      bad++; $display("FAIL halt_take flush=%b pc=%b bub=%b pe=%b want 1 0 1 1",
                      if_id_flush, pc_write, id_ex_bubble, pipe_enable);
    end
    tick();
    dec_halt = 0;
    for (int i = 1; i <= DRAIN; i++) begin
      @(negedge clock);
      total++;
      if (pc_write !== 0 || if_id_write !== 0 || id_ex_bubble !== 1 || pipe_enable !== 1 || program_done !== 0) begin
        bad++; $display("FAIL drain_cycle%0d pc=%b ifid=%b bub=%b pe=%b done=%b want 0 0 1 1 0",
                        i, pc_write, if_id_write, id_ex_bubble, pipe_enable, program_done);
      end
      tick();
    end
    halt_req = 1; run_req = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++;
      if (program_done !== 1 || halted !== 0 || pipe_enable !== 0 || pc_write !== 0) begin
        bad++; $display("FAIL done_hold%0d done=%b halted=%b pe=%b pc=%b want 1 0 0 0",
                        i, program_done, halted, pipe_enable, pc_write);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_debug();
    apply_reset();
    halt_req = 1;
    @(negedge clock);
    total++;
    if (pc_write !== 1 || halted !== 0) begin
      bad++; $display("FAIL halt_req_cycle pc=%b halted=%b want 1 0", pc_write, halted);
    end
    tick();
    halt_req = 0;
    @(negedge clock);
    total++;
    if (halted !== 1 || pc_write !== 0 || pipe_enable !== 0 || if_id_write !== 0) begin
      bad++; $display("FAIL halted_state halted=%b pc=%b pe=%b ifid=%b want 1 0 0 0",
                      halted, pc_write, pipe_enable, if_id_write);
    end
    tick();
    step_req = 1;
    @(negedge clock);
    total++;
    if (halted !== 1 || pc_write !== 0) begin
      bad++; $display("FAIL step_req_cycle halted=%b pc=%b want 1 0", halted, pc_write);
    end
    tick();
    step_req = 0;
    @(negedge clock);
    total++;
    if (halted !== 0 || pc_write !== 1) begin
      bad++; $display("FAIL step_advance halted=%b pc=%b want 0 1", halted, pc_write);
    end
    tick();
    @(negedge clock);
    total++;
    if (halted !== 1 || pc_write !== 0) begin
      bad++; $display("FAIL step_return halted=%b pc=%b want 1 0", halted, pc_write);
    end
    run_req = 1; step_req = 1;
    tick();
    run_req = 0; step_req = 0;
    tick();
    @(negedge clock);
    total++;
    if (halted !== 0 || pc_write !== 1) begin
      bad++; $display("FAIL run_wins halted=%b pc=%b want 0 1", halted, pc_write);
    end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    dec_halt = 1;
    tick();
    dec_halt = 0;
    tick();
    reset = 0;
    @(negedge clock);
    total++;
    if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_enable, halted, program_done} !== 7'b0) begin
      bad++; $display("FAIL reset_mid_drain got=%b want=0000000",
                      {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_enable, halted, program_done});
    end
    tick();
    reset = 1;
    for (int i = 0; i < DRAIN + 2; i++) begin
      @(negedge clock);
      total++;
      if (pc_write !== 1 || program_done !== 0) begin
        bad++; $display("FAIL after_reset_run%0d pc=%b done=%b want 1 0", i, pc_write, program_done);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    id_ex_mem_read = 1; id_ex_write_reg = 5'd7; dec_uses_rt = 1; rt_dec = 5'd7; rs_dec = 5'd1;
    for (int i = 0; i < 20; i++) tick();
    @(negedge clock);
    total++;
    if (s_stall_count !== 4'hF || stall_count !== 16'd20) begin
      bad++; $display("FAIL saturation small=%0d main=%0d want 15 20", s_stall_count, stall_count);
    end
    reset = 0;
    @(negedge clock);
    total++;
    if (s_stall_count !== 4'h0 || stall_count !== 16'd0 || id_ex_bubble !== 0) begin
      bad++; $display("FAIL saturation_reset small=%0d main=%0d bub=%b want 0 0 0",
                      s_stall_count, stall_count, id_ex_bubble);
    end
    tick();
    reset = 1;
    clear_inputs();
  endtask

  task automatic test_random();
    logic [6:0] exp_o;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      reset            = ($urandom_range(0, 149) != 0);
      rs_dec           = NB_REG'($urandom_range(0, 3));
      rt_dec           = NB_REG'($urandom_range(0, 3));
      id_ex_write_reg  = NB_REG'($urandom_range(0, 3));
      ex_mem_write_reg = NB_REG'($urandom_range(0, 3));
      dec_uses_rt      = 1'($urandom_range(0, 1));
      dec_is_branch    = ($urandom_range(0, 3) == 0);
      branch_taken     = 1'($urandom_range(0, 1));
      id_ex_reg_write  = 1'($urandom_range(0, 1));
      id_ex_mem_read   = ($urandom_range(0, 2) == 0);
      ex_mem_mem_read  = ($urandom_range(0, 2) == 0);
      dec_halt         = ($urandom_range(0, 39) == 0);
      halt_req         = ($urandom_range(0, 14) == 0);
      run_req          = ($urandom_range(0, 3) == 0);
      step_req         = ($urandom_range(0, 3) == 0);
      @(negedge clock);
      exp_o = model_outputs();
      total++;
      if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_enable, halted, program_done} !== exp_o) begin
        bad++; $display("FAIL random_outputs cycle=%0d got=%b want=%b", i,
                        {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_enable, halted, program_done}, exp_o);
      end
      total++;
      if (stall_count !== (reset ? NB_COUNT'(m_cnt) : NB_COUNT'(0))) begin
        bad++; $display("FAIL random_count cycle=%0d got=%0d want=%0d", i, stall_count, reset ? m_cnt : 0);
      end
      total++;
      if (s_stall_count !== (reset ? NB_SAT'(m_cnt_sat) : NB_SAT'(0))) begin
        bad++; $display("FAIL random_sat_count cycle=%0d got=%0d want=%0d", i, s_stall_count, reset ? m_cnt_sat : 0);
      end
      tick();
    end
    reset = 1;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    @(posedge clock);
    #1;
    test_reset();
    test_load_use();
    test_branch_on_load();
    test_reg_zero();
    test_halt_drain();
    test_debug();
    test_reset_mid_drain();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
